// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if: request/pixel bundle between the frame scheduler, its
// sprite drawers and the VGA writer.
// Ports: master = scheduler (drives draw_req and the vga_* pixel bus),
//        slave  = drawer/VGA side (drives done_in and the packed pixel slices).
interface draw_scheduler_if #(
   parameter int NUM_DRAWERS = 4
);
   logic [NUM_DRAWERS-1:0]   draw_req;
   logic [NUM_DRAWERS-1:0]   done_in;
   logic [8*NUM_DRAWERS-1:0] x_in;
   logic [7*NUM_DRAWERS-1:0] y_in;
   logic [3*NUM_DRAWERS-1:0] colour_in;
   logic [7:0]               vga_x;
   logic [6:0]               vga_y;
   logic [2:0]               vga_colour;
   logic                     vga_plot;

   modport master (
      output draw_req, vga_x, vga_y, vga_colour, vga_plot,
      input  done_in, x_in, y_in, colour_in
   );

   modport slave (
      input  draw_req, vga_x, vga_y, vga_colour, vga_plot,
      output done_in, x_in, y_in, colour_in
   );
endinterface

// File: rtl/draw_scheduler.sv
// draw_scheduler: shares one VGA plot port between NUM_DRAWERS sprite drawers,
//   running the enabled drawers one at a time in index order on each frame tick.
// Latency: vga_plot trails the drawer pixel by 1 cycle; each drawer costs its
//   length + 3 cycles; a frame adds one final SELECT and one FINISH cycle.
// Backpressure: none toward the VGA writer; a frame_tick while busy is dropped
//   and reported on overrun. Define DRAW_SCHEDULER_WATCHDOG_EN to abort a grant
//   after WD_CYCLES cycles without done (timeout pulse); otherwise timeout is 0.
// Ports: clk/reset (async, active-high); space_pressed (sync abort);
//   frame_tick, enable_mask (frame start and participants); bus (draw_req,
//   done_in, packed x/y/colour in, registered vga_x/y/colour/plot out);
//   busy, frame_done, overrun, timeout status.
module draw_scheduler #(
   parameter int NUM_DRAWERS = 4,
   parameter int IDX_W       = 2,
   parameter int WD_CYCLES   = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   space_pressed,
   input  logic                   frame_tick,
   input  logic [NUM_DRAWERS-1:0] enable_mask,
   draw_scheduler_if.master       bus,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   overrun,
   output logic                   timeout
);
   localparam int CNT_W = $clog2(WD_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, SELECT, GRANT, GAP, FINISH} state_t;

   state_t                 state;
   logic [NUM_DRAWERS-1:0] pending;
   logic [IDX_W-1:0]       cur;
   logic [CNT_W-1:0]       cnt;
   logic                   cur_done;

   assign cur_done = bus.done_in[cur];
   assign busy     = (state != IDLE);

   // Fixed priority: lowest index wins.
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_DRAWERS-1:0] v);
      lowest_idx = '0;
      for (int i = NUM_DRAWERS - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = IDX_W'(i);
      end
   endfunction

`ifndef DRAW_SCHEDULER_WATCHDOG_EN
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         pending        <= '0;
         cur            <= '0;
         cnt            <= '0;
         bus.draw_req   <= '0;
         bus.vga_x      <= '0;
         bus.vga_y      <= '0;
         bus.vga_colour <= '0;
         bus.vga_plot   <= 1'b0;
         frame_done     <= 1'b0;
         overrun        <= 1'b0;
`ifdef DRAW_SCHEDULER_WATCHDOG_EN
         timeout        <= 1'b0;
`endif
      end else begin
         // Pulse outputs default low every cycle.
         bus.vga_plot <= 1'b0;
         frame_done   <= 1'b0;
         overrun      <= 1'b0;
`ifdef DRAW_SCHEDULER_WATCHDOG_EN
         timeout      <= 1'b0;
`endif
         if (space_pressed) begin
            // Abort wins over everything, including a same-cycle frame_tick.
            state        <= IDLE;
            pending      <= '0;
            cur          <= '0;
            cnt          <= '0;
            bus.draw_req <= '0;
         end else begin
            // FINISH counts as busy, so a tick landing there is an overrun too.
            if (frame_tick && state != IDLE) overrun <= 1'b1;

            case (state)
               IDLE: begin
                  if (frame_tick) begin
                     pending <= enable_mask;
                     if (enable_mask == '0) begin
                        state      <= FINISH;
                        frame_done <= 1'b1;
                     end else begin
                        state <= SELECT;
                     end
                  end
               end

               SELECT: begin
                  if (pending == '0) begin
                     state      <= FINISH;
                     frame_done <= 1'b1;
                  end else begin
                     cur          <= lowest_idx(pending);
                     bus.draw_req <= NUM_DRAWERS'(1) << lowest_idx(pending);
                     cnt          <= '0;
                     state        <= GRANT;
                  end
               end

               GRANT: begin
                  if (cnt != '1) cnt <= cnt + CNT_W'(1);
                  // On the cnt==0 cycle the drawer has only just seen its
                  // request, so its registered pixel is still last frame's.
                  // The done cycle is still plotted: its pixel is the last one.
                  if (cnt != '0) begin
                     bus.vga_x      <= bus.x_in[8*cur +: 8];
                     bus.vga_y      <= bus.y_in[7*cur +: 7];
                     bus.vga_colour <= bus.colour_in[3*cur +: 3];
                     bus.vga_plot   <= 1'b1;
                  end
                  if (cur_done) begin
                     pending[cur] <= 1'b0;
                     bus.draw_req <= '0;
                     state        <= GAP;
                  end
`ifdef DRAW_SCHEDULER_WATCHDOG_EN
                  else if (cnt == CNT_W'(WD_CYCLES)) begin
                     pending[cur] <= 1'b0;
                     bus.draw_req <= '0;
                     timeout      <= 1'b1;
                     state        <= GAP;
                  end
`endif
               end

               // One request-free cycle so the drawer can drop its done flag
               // before the next grant is issued.
               GAP: state <= SELECT;

               FINISH: state <= IDLE;

               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
